note_dispatcher: RTL and testbench

Voice allocator and sequencer between the song reader and a bank of `note_player` voices. Accepts notes over a valid/ready handshake and assigns each non-rest note to a free voice using round-robin order. It drives that voice's `load_new_note` pulse together with the shared note/duration bus. A rest (note 0) is timed internally in beats, and no note is accepted while the rest is running.

---
 rtl/note_dispatcher_if.sv | 30 +++
 rtl/note_dispatcher.sv | 106 ++++++++++
 tb/tb_note_dispatcher.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_dispatcher_if.sv
// Song-reader / voice-bank signal bundle for the note dispatcher.
// master drives notes, play/beat and voice completion; slave is the dispatcher.
interface note_dispatcher_if #(
    parameter int unsigned NUM_VOICES = 3,
    parameter int unsigned NOTE_W     = 6,
    parameter int unsigned DUR_W      = 6
);
    logic                  play;
    logic                  beat;
    logic                  note_valid;
    logic [NOTE_W-1:0]     note;
    logic [DUR_W-1:0]      duration;
    logic                  note_ready;
    logic [NUM_VOICES-1:0] voice_load;
    logic [NOTE_W-1:0]     voice_note;
    logic [DUR_W-1:0]      voice_duration;
    logic [NUM_VOICES-1:0] voice_done;
    logic [NUM_VOICES-1:0] voice_busy;
    logic                  all_idle;

    modport master (
        output play, beat, note_valid, note, duration, voice_done,
        input  note_ready, voice_load, voice_note, voice_duration, voice_busy, all_idle
    );

    modport slave (
        input  play, beat, note_valid, note, duration, voice_done,
        output note_ready, voice_load, voice_note, voice_duration, voice_busy, all_idle
    );
endinterface

// File: rtl/note_dispatcher.sv
// Round-robin voice allocator and rest sequencer between the song reader
// and a bank of note_player voices.
module note_dispatcher #(
    parameter int unsigned NUM_VOICES = 3,
    parameter int unsigned NOTE_W     = 6,
    parameter int unsigned DUR_W      = 6
) (
    input  logic               clk,
    input  logic               reset,
    note_dispatcher_if.slave   bus
);
    localparam int unsigned PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_REST = 2'd2
    } state_t;

    state_t                r_state;
    logic [PTR_W-1:0]      r_ptr;
    logic [NUM_VOICES-1:0] r_busy;
    logic [NUM_VOICES-1:0] r_load;
    logic [NOTE_W-1:0]     r_vnote;
    logic [DUR_W-1:0]      r_vdur;
    logic [DUR_W-1:0]      r_rest_cnt;

    logic [PTR_W-1:0]      w_pick;
    logic                  w_any_free;
    logic                  w_is_rest;
    logic                  w_xfer;
    logic [NUM_VOICES-1:0] w_busy_nxt;

    // First free voice searching upward from ptr+1 with wrap.
    always_comb begin
        w_pick     = '0;
        w_any_free = 1'b0;
        for (int unsigned k = 1; k <= NUM_VOICES; k++) begin
            if (!w_any_free && !r_busy[PTR_W'((32'(r_ptr) + k) % NUM_VOICES)]) begin
                w_pick     = PTR_W'((32'(r_ptr) + k) % NUM_VOICES);
                w_any_free = 1'b1;
            end
        end
    end

    assign w_is_rest      = (bus.note == '0);
    assign bus.note_ready = reset && (r_state == S_IDLE) && bus.play && (w_is_rest || w_any_free);
    assign w_xfer         = bus.note_valid && bus.note_ready;

    // r_load is nonzero only in LOAD, so OR-ing it last lets the set beat a same-cycle release.
    assign w_busy_nxt = (r_busy & ~bus.voice_done) | r_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= PTR_W'(NUM_VOICES - 1);
            r_busy     <= '0;
            r_load     <= '0;
            r_vnote    <= '0;
            r_vdur     <= '0;
            r_rest_cnt <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_load <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        if (w_is_rest) begin
                            r_rest_cnt <= bus.duration;
                            r_state    <= S_REST;
                        end else begin
                            r_ptr   <= w_pick;
                            r_load  <= NUM_VOICES'(1) << w_pick;
                            r_vnote <= bus.note;
                            r_vdur  <= bus.duration;
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    r_state <= S_IDLE;
                end
                S_REST: begin
                    if (r_rest_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else if (bus.beat && bus.play) begin
                        r_rest_cnt <= r_rest_cnt - DUR_W'(1);
                        if (r_rest_cnt == DUR_W'(1)) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.voice_load     = r_load;
    assign bus.voice_note     = r_vnote;
    assign bus.voice_duration = r_vdur;
    assign bus.voice_busy     = r_busy;
    assign bus.all_idle       = (r_state == S_IDLE) && (r_busy == '0);

endmodule

// File: tb/tb_note_dispatcher.sv
// Self-checking bench for note_dispatcher: directed vector table, hand-written
// rest/pause/reset sequences, then random traffic against a behavioural model.
module tb_note_dispatcher;
    localparam int unsigned NV = 3;
    localparam int unsigned NW = 6;
    localparam int unsigned DW = 6;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    note_dispatcher_if #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW)) dif ();

    note_dispatcher #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic          play;
        logic          valid;
        logic [NW-1:0] note;
        logic [DW-1:0] dur;
        logic [NV-1:0] done;
        logic          ready;
        logic [NV-1:0] load;
        logic [NV-1:0] busy;
        logic [NW-1:0] vnote;
        logic [DW-1:0] vdur;
    } vec_t;

    vec_t tbl[15];

    // Behavioural model state
    bit            m_busy[NV];
    int            m_ptr;
    int            m_load;
    int            m_rest;
    logic [NW-1:0] m_vnote;
    logic [DW-1:0] m_vdur;

    logic          rp, rv, rb, hold;
    logic [NW-1:0] rn;
    logic [DW-1:0] rd;
    logic [NV-1:0] rdn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic p, input logic v, input logic [NW-1:0] n,
                          input logic [DW-1:0] d, input logic b, input logic [NV-1:0] dn);
        dif.play       = p;
        dif.note_valid = v;
        dif.note       = n;
        dif.duration   = d;
        dif.beat       = b;
        dif.voice_done = dn;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic p, input logic v, input int n, input int d,
                                input int dn, input logic r, input int ld, input int bz,
                                input int vn, input int vd);
        vec_t t;
        t.play  = p;
        t.valid = v;
        t.note  = NW'(n);
        t.dur   = DW'(d);
        t.done  = NV'(dn);
        t.ready = r;
        t.load  = NV'(ld);
        t.busy  = NV'(bz);
        t.vnote = NW'(vn);
        t.vdur  = DW'(vd);
        return t;
    endfunction

    initial begin
        // play, valid, note, dur, done | ready, load, busy, vnote, vdur
        tbl[0]  = mk(1, 1, 10, 8, 0,  1, 0, 0, 0,  0);
        tbl[1]  = mk(1, 1, 20, 8, 0,  0, 1, 0, 10, 8);
        tbl[2]  = mk(1, 1, 20, 8, 0,  1, 0, 1, 10, 8);
        tbl[3]  = mk(1, 1, 30, 8, 0,  0, 2, 1, 20, 8);
        tbl[4]  = mk(1, 1, 30, 8, 0,  1, 0, 3, 20, 8);
        tbl[5]  = mk(1, 1, 40, 8, 0,  0, 4, 3, 30, 8);
        tbl[6]  = mk(1, 1, 40, 8, 0,  0, 0, 7, 30, 8);
        tbl[7]  = mk(1, 1, 40, 8, 2,  0, 0, 7, 30, 8);
        tbl[8]  = mk(1, 1, 40, 8, 0,  1, 0, 5, 30, 8);
        tbl[9]  = mk(1, 0, 0,  0, 0,  0, 2, 5, 40, 8);
        tbl[10] = mk(1, 0, 40, 8, 0,  0, 0, 7, 40, 8);
        tbl[11] = mk(1, 0, 40, 8, 1,  0, 0, 7, 40, 8);
        tbl[12] = mk(1, 1, 50, 9, 0,  1, 0, 6, 40, 8);
        tbl[13] = mk(1, 0, 0,  0, 1,  0, 1, 6, 50, 9);
        tbl[14] = mk(1, 0, 0,  0, 0,  1, 0, 7, 50, 9);

        // Reset state, with play and a valid note presented during reset
        set_in(1, 1, 5, 3, 0, 0);
        reset = 1'b0;
        tick();
        tick();
        check("rst.ready", 32'(dif.note_ready), 0);
        check("rst.load", 32'(dif.voice_load), 0);
        check("rst.busy", 32'(dif.voice_busy), 0);
        check("rst.vnote", 32'(dif.voice_note), 0);
        check("rst.vdur", 32'(dif.voice_duration), 0);
        check("rst.all_idle", 32'(dif.all_idle), 1);
        reset = 1'b1;

        // Chord allocation, back-pressure, simultaneous set/release
        for (int i = 0; i < 15; i++) begin
            set_in(tbl[i].play, tbl[i].valid, tbl[i].note, tbl[i].dur, 1'b0, tbl[i].done);
            #1;
            check($sformatf("tbl%0d.ready", i), 32'(dif.note_ready), 32'(tbl[i].ready));
            check($sformatf("tbl%0d.load", i), 32'(dif.voice_load), 32'(tbl[i].load));
            check($sformatf("tbl%0d.busy", i), 32'(dif.voice_busy), 32'(tbl[i].busy));
            check($sformatf("tbl%0d.vnote", i), 32'(dif.voice_note), 32'(tbl[i].vnote));
            check($sformatf("tbl%0d.vdur", i), 32'(dif.voice_duration), 32'(tbl[i].vdur));
            tick();
        end

        // Rest of 3 beats, beat every 10 cycles
        set_in(1, 1, 0, 3, 0, 0);
        #1;
        check("rest3.accept", 32'(dif.note_ready), 1);
        tick();
        for (int i = 1; i <= 31; i++) begin
            set_in(1, 0, 0, 0, (i % 10) == 0, 0);
            #1;
            check($sformatf("rest3.c%0d", i), 32'(dif.note_ready), 32'(i == 31));
            tick();
        end

        // Zero-duration rest
        set_in(1, 1, 0, 0, 0, 0);
        #1;
        check("rest0.accept", 32'(dif.note_ready), 1);
        tick();
        set_in(1, 0, 0, 0, 0, 0);
        #1;
        check("rest0.c1", 32'(dif.note_ready), 0);
        tick();
        check("rest0.c2", 32'(dif.note_ready), 1);

        // Pause mid-rest: counter frozen while play is low
        set_in(1, 1, 0, 2, 0, 0);
        #1;
        check("pause.accept", 32'(dif.note_ready), 1);
        tick();
        for (int i = 1; i <= 11; i++) begin
            logic paused;
            paused = (i >= 4) && (i <= 8);
            set_in(!paused, 0, 0, 0, (i == 3) || paused || (i == 10), 0);
            #1;
            check($sformatf("pause.c%0d", i), 32'(dif.note_ready), 32'(i == 11));
            tick();
        end
        set_in(0, 1, 0, 1, 0, 0);
        #1;
        check("pause.idle_noplay", 32'(dif.note_ready), 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0);
        #1;
        check("pause.no_xfer", 32'(dif.note_ready), 1);

        // Async reset during LOAD
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_in(1, 1, 11, 4, 0, 0);
        #1;
        check("areset.acc0", 32'(dif.note_ready), 1);
        tick();
        set_in(1, 1, 12, 5, 0, 0);
        #1;
        check("areset.load0", 32'(dif.voice_load), 1);
        tick();
        check("areset.acc1", 32'(dif.note_ready), 1);
        tick();
        check("areset.load1", 32'(dif.voice_load), 2);
        #2;
        reset = 1'b0;
        #1;
        check("areset.load_clr", 32'(dif.voice_load), 0);
        check("areset.busy_clr", 32'(dif.voice_busy), 0);
        check("areset.vnote_clr", 32'(dif.voice_note), 0);
        check("areset.vdur_clr", 32'(dif.voice_duration), 0);
        check("areset.all_idle", 32'(dif.all_idle), 1);
        check("areset.ready", 32'(dif.note_ready), 0);
        tick();
        reset = 1'b1;
        set_in(1, 1, 13, 6, 0, 0);
        #1;
        check("areset.acc2", 32'(dif.note_ready), 1);
        tick();
        check("areset.voice0", 32'(dif.voice_load), 1);
        check("areset.vnote13", 32'(dif.voice_note), 13);

        // Random traffic against the behavioural model
        set_in(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < NV; i++) m_busy[i] = 1'b0;
        m_ptr   = NV - 1;
        m_load  = -1;
        m_rest  = -1;
        m_vnote = '0;
        m_vdur  = '0;
        hold    = 1'b0;
        rn      = '0;
        rd      = '0;
        rv      = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            bit            idle;
            bit            e_ready;
            int            pick;
            logic [NV-1:0] e_load;
            logic [NV-1:0] e_busy;

            rp  = ($urandom % 16) != 0;
            rb  = ($urandom % 3) == 0;
            for (int i = 0; i < NV; i++) rdn[i] = ($urandom % 6) == 0;
            if (!hold) begin
                rv = ($urandom % 3) != 0;
                if ($urandom % 4 == 0) rn = '0;
                else rn = NW'($urandom_range(1, 63));
                rd = (rn == '0) ? DW'($urandom_range(0, 3)) : DW'($urandom_range(0, 63));
            end
            set_in(rp, rv, rn, rd, rb, rdn);
            #1;

            idle = (m_load < 0) && (m_rest < 0);
            pick = -1;
            for (int k = 1; k <= NV; k++) begin
                int j;
                j = (m_ptr + k) % NV;
                if (pick < 0 && !m_busy[j]) pick = j;
            end
            e_ready = idle && rp && (rn == '0 || pick >= 0);
            e_load  = '0;
            if (m_load >= 0) e_load[m_load] = 1'b1;
            for (int i = 0; i < NV; i++) e_busy[i] = m_busy[i];

            check("rnd.ready", 32'(dif.note_ready), 32'(e_ready));
            check("rnd.load", 32'(dif.voice_load), 32'(e_load));
            check("rnd.busy", 32'(dif.voice_busy), 32'(e_busy));
            check("rnd.vnote", 32'(dif.voice_note), 32'(m_vnote));
            check("rnd.vdur", 32'(dif.voice_duration), 32'(m_vdur));
            check("rnd.all_idle", 32'(dif.all_idle), 32'(idle && (e_busy == '0)));
            tick();

            for (int i = 0; i < NV; i++) if (rdn[i]) m_busy[i] = 1'b0;
            if (m_load >= 0) m_busy[m_load] = 1'b1;
            m_load = -1;
            if (m_rest == 0) begin
                m_rest = -1;
            end else if (m_rest > 0 && rb && rp) begin
                m_rest--;
                if (m_rest == 0) m_rest = -1;
            end
            if (rv && e_ready) begin
                if (rn == '0) begin
                    m_rest = int'(rd);
                end else begin
                    m_load  = pick;
                    m_ptr   = pick;
                    m_vnote = rn;
                    m_vdur  = rd;
                end
            end
            hold = rv && !e_ready;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
